parallel_to_serial_stream: RTL

//   Parametrised, backpressure-aware parallel-to-serial converter. It accepts DATA_W-bit words

---
 rtl/parallel_to_serial_stream.sv | 129 ++++++++++++
 1 files changed

// File: rtl/parallel_to_serial_stream.sv
// -----------------------------------------------------------------------------
// parallel_to_serial_stream
//   Backpressure-aware parallel-to-serial converter. Words arrive over a
//   valid/ready handshake into a one-word holding register. Each word is then
//   shifted out one bit per accepted serial transfer, LSB- or MSB-first as
//   selected per word. Because the holding register refills the shifter on
//   the same edge that the last bit leaves, consecutive words stream with no
//   idle cycle between them.
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous active-low reset (0 = reset asserted)
//   parallel_i        word to serialise
//   parallel_valid_i  parallel_i / msb_first_i are valid
//   msb_first_i       1 = send bit DATA_W-1 first, 0 = send bit 0 first
//   parallel_ready_o  holding register can accept a word
//   serial_o          current serial bit (0 while idle)
//   valid_o           serial_o carries a bit of a word
//   last_o            serial_o is the final bit of the current word
//   serial_ready_i    consumer takes serial_o this cycle
//   empty_o           no word held and none being shifted
// -----------------------------------------------------------------------------
module parallel_to_serial_stream #(
  parameter  int DATA_W = 8,
  localparam int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] parallel_i,
  input  logic              parallel_valid_i,
  input  logic              msb_first_i,
  output logic              parallel_ready_o,
  output logic              serial_o,
  output logic              valid_o,
  output logic              last_o,
  input  logic              serial_ready_i,
  output logic              empty_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  // Holding register
  logic [DATA_W-1:0] hold_data;
  logic              hold_msb_first;
  logic              hold_valid;

  // Shifter
  logic [DATA_W-1:0] shift_reg;
  logic              shift_msb_first;
  logic [CNT_W-1:0]  cnt;
  logic              active;

  // Per-edge events
  logic accept;
  logic transfer;
  logic last_transfer;
  logic load;

  assign accept        = parallel_valid_i & ~hold_valid;
  assign transfer      = active & serial_ready_i;
  assign last_transfer = transfer & (cnt == LAST_CNT);
  // Refill either an idle shifter or one whose final bit leaves this edge,
  // so back-to-back words need no bubble.
  assign load          = hold_valid & (~active | last_transfer);

  // NOTE: every output is assigned a default first so no path through the
  // block leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    parallel_ready_o = ~hold_valid;
    valid_o          = active;
    empty_o          = ~active & ~hold_valid;
    serial_o         = 1'b0;
    last_o           = 1'b0;
    if (active) begin
      // The bit on the wire is always the edge of the shift register that
      // the word's own bit order shifts out of.
      serial_o = shift_msb_first ? shift_reg[DATA_W-1] : shift_reg[0];
      last_o   = (cnt == LAST_CNT);
    end
  end

  // NOTE: the data registers are reset along with the flags; reset must
  // discard any word in flight, and clearing the data keeps the idle state
  // fully deterministic at negligible cost for a single word of storage.
  // Holding register: accept and load are mutually exclusive because ready
  // is low whenever hold is full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_data      <= '0;
      hold_msb_first <= 1'b0;
      hold_valid     <= 1'b0;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      hold_data      <= parallel_i;
      hold_msb_first <= msb_first_i;
      hold_valid     <= 1'b1;
    end else if (load) begin
      hold_valid     <= 1'b0;
    end
  end

  // Shifter: the bit order is latched with the word, so later words'
  // msb_first_i cannot disturb a word already being shifted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg       <= '0;
      shift_msb_first <= 1'b0;
      cnt             <= '0;
      active          <= 1'b0;
    end else if (load) begin
      shift_reg       <= hold_data;
      shift_msb_first <= hold_msb_first;
      cnt             <= '0;
      active          <= 1'b1;
    end else if (transfer) begin
      if (last_transfer) begin
        // Nothing waiting in hold: go idle; cnt parks at 0 rather than wrap.
        active <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (shift_msb_first) shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
      else                 shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
    end
  end

endmodule
